// File: rtl/reg_read_stage.sv
// Register-read stage: 8x16 register file, pending scoreboard, registered operands to execute.
// Optional write-through bypass from write-back is enabled with `define RF_BYPASS_EN.
module reg_read_stage #(
  parameter int DATA_W = 16,
  parameter int ADDR_W = 3,
  parameter int NREGS  = 1 << ADDR_W,
  parameter int OP_W   = 16
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [ADDR_W-1:0] in_rs1,
  input  logic [ADDR_W-1:0] in_rs2,
  input  logic [ADDR_W-1:0] in_rd,
  input  logic              in_rd_we,
  input  logic [OP_W-1:0]   in_op,
  input  logic              wb_en,
  input  logic [ADDR_W-1:0] wb_addr,
  input  logic [DATA_W-1:0] wb_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_rs1_data,
  output logic [DATA_W-1:0] out_rs2_data,
  output logic [ADDR_W-1:0] out_rd,
  output logic              out_rd_we,
  output logic [OP_W-1:0]   out_op
);

  logic [DATA_W-1:0] rf_q [NREGS];
  logic [NREGS-1:0]  pend_q, pend_d;
  logic [NREGS-1:0]  wb_clr, pend_eff;
  logic [DATA_W-1:0] rs1_val, rs2_val;
  logic              hazard, accept;

  logic              vld_q;
  logic [DATA_W-1:0] rs1_q, rs2_q;
  logic [ADDR_W-1:0] rd_q;
  logic              we_q;
  logic [OP_W-1:0]   op_q;

  always_comb begin
    wb_clr = '0;
    if (wb_en) wb_clr[wb_addr] = 1'b1;
  end

`ifdef RF_BYPASS_EN
  // A register being written back this cycle is already resolved.
  always_comb begin
    pend_eff = pend_q & ~wb_clr;
    rs1_val  = wb_clr[in_rs1] ? wb_data : rf_q[in_rs1];
    rs2_val  = wb_clr[in_rs2] ? wb_data : rf_q[in_rs2];
  end
`else
  always_comb begin
    pend_eff = pend_q;
    rs1_val  = rf_q[in_rs1];
    rs2_val  = rf_q[in_rs2];
  end
`endif

  always_comb begin
    hazard = pend_eff[in_rs1] | pend_eff[in_rs2]
           | (in_rd_we & pend_eff[in_rd]);
    in_ready = !reset && !hazard && (!vld_q || out_ready);
    accept = in_valid && in_ready;
  end

  // Set on accept overrides a same-cycle clear.
  always_comb begin
    pend_d = pend_q & ~wb_clr;
    if (accept && in_rd_we) pend_d[in_rd] = 1'b1;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < NREGS; i++) rf_q[i] <= '0;
      pend_q <= '0;
      vld_q  <= 1'b0;
      rs1_q  <= '0;
      rs2_q  <= '0;
      rd_q   <= '0;
      we_q   <= 1'b0;
      op_q   <= '0;
    end else begin
      if (wb_en) rf_q[wb_addr] <= wb_data;
      pend_q <= pend_d;
      if (accept) begin
        vld_q <= 1'b1;
        rs1_q <= rs1_val;
        rs2_q <= rs2_val;
        rd_q  <= in_rd;
        we_q  <= in_rd_we;
        op_q  <= in_op;
      end else if (out_ready) begin
        vld_q <= 1'b0;
      end
    end
  end

  assign out_valid    = vld_q;
  assign out_rs1_data = rs1_q;
  assign out_rs2_data = rs2_q;
  assign out_rd       = rd_q;
  assign out_rd_we    = we_q;
  assign out_op       = op_q;

endmodule

// File: tb/tb_reg_read_stage.sv
// Scoreboard bench for reg_read_stage; stall expectations follow RF_BYPASS_EN.
// Driver pushes expected operands on accept, monitor pops on each output handshake.
module tb_reg_read_stage;

`ifdef RF_BYPASS_EN
  localparam int EXTRA = 0;
`else
  localparam int EXTRA = 1;
`endif

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [2:0]  in_rs1 = '0, in_rs2 = '0, in_rd = '0;
  logic        in_rd_we = 1'b0;
  logic [15:0] in_op = '0;
  logic        wb_en = 1'b0;
  logic [2:0]  wb_addr = '0;
  logic [15:0] wb_data = '0;
  logic        out_valid;
  logic        out_ready = 1'b1;
  logic [15:0] out_rs1_data, out_rs2_data;
  logic [2:0]  out_rd;
  logic        out_rd_we;
  logic [15:0] out_op;

  typedef struct packed {
    logic [15:0] r1;
    logic [15:0] r2;
    logic [2:0]  rd;
    logic        we;
    logic [15:0] op;
  } exp_t;

  exp_t sb[$];
  int   checks = 0;
  int   errors = 0;
  int   st;

  reg_read_stage dut (
    .clk(clk), .reset(reset),
    .in_valid(in_valid), .in_ready(in_ready),
    .in_rs1(in_rs1), .in_rs2(in_rs2), .in_rd(in_rd),
    .in_rd_we(in_rd_we), .in_op(in_op),
    .wb_en(wb_en), .wb_addr(wb_addr), .wb_data(wb_data),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_rs1_data(out_rs1_data), .out_rs2_data(out_rs2_data),
    .out_rd(out_rd), .out_rd_we(out_rd_we), .out_op(out_op)
  );

  always #5 clk = ~clk;

  task automatic chk(input string n, input logic [31:0] a,
                     input logic [31:0] e);
    checks++;
    if (a !== e) begin
      errors++;
      $display("FAIL %s: got %h expected %h", n, a, e);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Monitor: compare every output handshake against the scoreboard.
  always @(negedge clk) begin
    if (!reset && out_valid && out_ready) begin
      if (sb.size() == 0) begin
        chk("sb_underflow", 32'd1, 32'd0);
      end else begin
        exp_t e;
        e = sb.pop_front();
        chk("rs1_data", {16'd0, out_rs1_data}, {16'd0, e.r1});
        chk("rs2_data", {16'd0, out_rs2_data}, {16'd0, e.r2});
        chk("rd", {29'd0, out_rd}, {29'd0, e.rd});
        chk("rd_we", {31'd0, out_rd_we}, {31'd0, e.we});
        chk("op", {16'd0, out_op}, {16'd0, e.op});
      end
    end
  end

  task automatic issue(input logic [2:0] rs1, input logic [2:0] rs2,
                       input logic [2:0] rd, input logic we,
                       input logic [15:0] op, input logic [15:0] e1,
                       input logic [15:0] e2, output int stalls);
    exp_t e;
    in_rs1 = rs1; in_rs2 = rs2; in_rd = rd;
    in_rd_we = we; in_op = op; in_valid = 1'b1;
    stalls = 0;
    forever begin
      @(negedge clk);
      if (in_ready) break;
      stalls++;
      if (stalls > 50) begin
        chk("accept_timeout", 32'd1, 32'd0);
        in_valid = 1'b0;
        return;
      end
    end
    e.r1 = e1; e.r2 = e2; e.rd = rd; e.we = we; e.op = op;
    sb.push_back(e);
    @(posedge clk);
    #1;
    in_valid = 1'b0;
  endtask

  task automatic wb_after(input int n, input logic [2:0] a,
                          input logic [15:0] d);
    repeat (n) tick();
    wb_en = 1'b1; wb_addr = a; wb_data = d;
    tick();
    wb_en = 1'b0;
  endtask

  initial begin
    // Reset state
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_in_ready", {31'd0, in_ready}, 32'd0);
    chk("rst_out_valid", {31'd0, out_valid}, 32'd0);
    @(posedge clk); #1;
    reset = 1'b0;
    @(negedge clk);
    chk("post_rst_rs1", {16'd0, out_rs1_data}, 32'd0);
    chk("post_rst_op", {16'd0, out_op}, 32'd0);
    chk("post_rst_ready", {31'd0, in_ready}, 32'd1);

    // Write-back then read
    @(posedge clk); #1;
    wb_after(0, 3'd3, 16'h1234);
    issue(3'd3, 3'd0, 3'd0, 1'b0, 16'hA001, 16'h1234, 16'h0000, st);
    chk("wb_read_stalls", st, 0);

    // Back-to-back throughput
    issue(3'd0, 3'd3, 3'd7, 1'b0, 16'hA002, 16'h0000, 16'h1234, st);
    chk("b2b_stall0", st, 0);
    issue(3'd3, 3'd3, 3'd6, 1'b0, 16'hA003, 16'h1234, 16'h1234, st);
    chk("b2b_stall1", st, 0);

    // RAW on rs2
    issue(3'd0, 3'd0, 3'd5, 1'b1, 16'hB005, 16'h0000, 16'h0000, st);
    fork
      issue(3'd0, 3'd5, 3'd1, 1'b0, 16'hB006, 16'h0000, 16'hBEEF, st);
      wb_after(3, 3'd5, 16'hBEEF);
    join
    chk("raw_stalls", st, 3 + EXTRA);

    // WAW on r2, pending stays set afterward
    issue(3'd0, 3'd0, 3'd2, 1'b1, 16'hC001, 16'h0000, 16'h0000, st);
    fork
      issue(3'd0, 3'd0, 3'd2, 1'b1, 16'hC002, 16'h0000, 16'h0000, st);
      wb_after(3, 3'd2, 16'h0202);
    join
    chk("waw_stalls", st, 3 + EXTRA);
    fork
      issue(3'd2, 3'd0, 3'd0, 1'b0, 16'hC003, 16'h2222, 16'h0000, st);
      wb_after(2, 3'd2, 16'h2222);
    join
    chk("waw_pending_stalls", st, 2 + EXTRA);

    // Backpressure
    tick();
    out_ready = 1'b0;
    issue(3'd3, 3'd0, 3'd1, 1'b0, 16'hB001, 16'h1234, 16'h0000, st);
    chk("bp_a_stalls", st, 0);
    in_rs1 = 3'd5; in_valid = 1'b1;
    repeat (4) begin
      @(negedge clk);
      chk("bp_in_ready", {31'd0, in_ready}, 32'd0);
      chk("bp_out_valid", {31'd0, out_valid}, 32'd1);
      chk("bp_rs1_hold", {16'd0, out_rs1_data}, 32'h1234);
      chk("bp_op_hold", {16'd0, out_op}, 32'hB001);
    end
    @(posedge clk); #1;
    out_ready = 1'b1;
    issue(3'd5, 3'd2, 3'd0, 1'b0, 16'hB002, 16'hBEEF, 16'h2222, st);
    chk("bp_b_stalls", st, 0);

    // Simultaneous accept and write-back on r4
    wb_en = 1'b1; wb_addr = 3'd4; wb_data = 16'h4444;
    issue(3'd0, 3'd0, 3'd4, 1'b1, 16'hE001, 16'h0000, 16'h0000, st);
    wb_en = 1'b0;
    chk("sim_stalls", st, 0);
    fork
      issue(3'd4, 3'd0, 3'd0, 1'b0, 16'hE002, 16'h4545, 16'h0000, st);
      wb_after(2, 3'd4, 16'h4545);
    join
    chk("sim_pending_stalls", st, 2 + EXTRA);

    // Reset mid-operation
    tick();
    out_ready = 1'b0;
    issue(3'd0, 3'd0, 3'd1, 1'b1, 16'hD001, 16'h0000, 16'h0000, st);
    chk("mid_out_valid", {31'd0, out_valid}, 32'd1);
    reset = 1'b1;
    sb.delete();
    @(negedge clk);
    chk("mid_rst_in_ready", {31'd0, in_ready}, 32'd0);
    @(posedge clk); #1;
    reset = 1'b0;
    @(negedge clk);
    chk("mid_rst_valid", {31'd0, out_valid}, 32'd0);
    chk("mid_rst_op", {16'd0, out_op}, 32'd0);
    chk("mid_rst_rd", {29'd0, out_rd}, 32'd0);
    chk("mid_rst_we", {31'd0, out_rd_we}, 32'd0);
    @(posedge clk); #1;
    out_ready = 1'b1;
    issue(3'd1, 3'd3, 3'd0, 1'b0, 16'hD002, 16'h0000, 16'h0000, st);
    chk("mid_rst_no_stall", st, 0);
    wb_after(0, 3'd6, 16'h6666);
    issue(3'd0, 3'd6, 3'd0, 1'b0, 16'hD003, 16'h0000, 16'h6666, st);
    chk("post_rst_wb_stalls", st, 0);

    repeat (3) tick();
    chk("sb_drained", sb.size(), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: got running expected finished");
    $fatal(1);
  end

endmodule
